// File: rtl/w_writeback_stage_if.sv
// -----------------------------------------------------------------------------
// w_writeback_stage_if
// Bundles the M-stage results that feed the M/W pipeline register and the
// W-stage write interface it drives.
//   M side (into the stage): M_Valid, M_RegWrite, M_A3, M_WDSel, M_LoadType,
//                            M_ALUResult, M_MemRData, M_PC
//   W side (out of stage)  : W_RegWrite, W_A3, W_RegData, W_PC, W_Valid,
//                            W_RetireCount
// Modports:
//   master - the upstream pipeline / environment: drives M_*, observes W_*
//   slave  - the writeback stage: reads M_*, drives W_*
// -----------------------------------------------------------------------------
interface w_writeback_stage_if;
  logic        M_Valid;
  logic        M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_WDSel;
  logic [2:0]  M_LoadType;
  logic [31:0] M_ALUResult;
  logic [31:0] M_MemRData;
  logic [31:0] M_PC;

  logic        W_RegWrite;
  logic [4:0]  W_A3;
  logic [31:0] W_RegData;
  logic [31:0] W_PC;
  logic        W_Valid;
  logic [31:0] W_RetireCount;

  modport master (
    output M_Valid, M_RegWrite, M_A3, M_WDSel, M_LoadType,
           M_ALUResult, M_MemRData, M_PC,
    input  W_RegWrite, W_A3, W_RegData, W_PC, W_Valid, W_RetireCount
  );

  modport slave (
    input  M_Valid, M_RegWrite, M_A3, M_WDSel, M_LoadType,
           M_ALUResult, M_MemRData, M_PC,
    output W_RegWrite, W_A3, W_RegData, W_PC, W_Valid, W_RetireCount
  );
endinterface

// File: rtl/w_writeback_stage.sv
// -----------------------------------------------------------------------------
// w_writeback_stage
// M/W pipeline register and writeback-value source for the five-stage MIPS
// core. Latches M-stage results every cycle (no stall), then combinationally
// selects the GRF write data from the latched fields: ALU result, extracted
// and extended load data, or PC+8 (link). Also counts retired instructions.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; overrides every other input
//   wb     - w_writeback_stage_if.slave: M_* inputs, W_* outputs
// Parameters:
//   RESET_PC - W_PC after reset
// -----------------------------------------------------------------------------
module w_writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   reset,
  w_writeback_stage_if.slave     wb
);

  typedef enum logic [1:0] {
    WD_ALU  = 2'b00,
    WD_MEM  = 2'b01,
    WD_PC8  = 2'b10,
    WD_RSVD = 2'b11
  } wd_sel_e;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

  // Latched M-stage fields.
  logic        valid_q;
  logic        reg_write_q;
  logic [4:0]  a3_q;
  wd_sel_e     wd_sel_q;
  load_type_e  load_type_q;
  logic [31:0] alu_result_q;
  logic [31:0] mem_rdata_q;
  logic [31:0] pc_q;
  logic [31:0] retire_cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order inside the block.
  // NOTE: the data registers are reset too (not just the control bits) so
  // W_RegData and W_PC read defined values straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      a3_q         <= '0;
      wd_sel_q     <= WD_ALU;
      load_type_q  <= LT_LW;
      alu_result_q <= '0;
      mem_rdata_q  <= '0;
      pc_q         <= RESET_PC;
      retire_cnt_q <= '0;
    end else begin
      // Counts the instruction currently sitting in W as it leaves; wraps
      // naturally at 2^32.
      if (valid_q) retire_cnt_q <= retire_cnt_q + 32'd1;
      valid_q      <= wb.M_Valid;
      reg_write_q  <= wb.M_RegWrite;
      a3_q         <= wb.M_A3;
      wd_sel_q     <= wd_sel_e'(wb.M_WDSel);
      load_type_q  <= load_type_e'(wb.M_LoadType);
      alu_result_q <= wb.M_ALUResult;
      mem_rdata_q  <= wb.M_MemRData;
      // Bubbles latch their PC too, keeping the W_PC trace monotonic.
      pc_q         <= wb.M_PC;
    end
  end

  // Load extraction: pick the addressed lane (little-endian), then extend.
  logic [1:0]  load_off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_word;

  assign load_off = alu_result_q[1:0];

  // NOTE: every always_comb output is given a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    load_byte = mem_rdata_q[7:0];
    case (load_off)
      2'd1:    load_byte = mem_rdata_q[15:8];
      2'd2:    load_byte = mem_rdata_q[23:16];
      2'd3:    load_byte = mem_rdata_q[31:24];
      default: load_byte = mem_rdata_q[7:0];
    endcase

    // Halfword lane is chosen by off[1] only; a misaligned off[0] is ignored.
    load_half = load_off[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];

    load_word = mem_rdata_q;
    case (load_type_q)
      LT_LB:   load_word = {{24{load_byte[7]}}, load_byte};
      LT_LBU:  load_word = {24'd0, load_byte};
      LT_LH:   load_word = {{16{load_half[15]}}, load_half};
      LT_LHU:  load_word = {16'd0, load_half};
      default: load_word = mem_rdata_q;   // lw and undefined encodings
    endcase
  end

  // Writeback source select; a bubble always presents 0.
  logic [31:0] reg_data;

  always_comb begin
    reg_data = alu_result_q;
    case (wd_sel_q)
      WD_MEM:  reg_data = load_word;
      WD_PC8:  reg_data = pc_q + 32'd8;
      default: reg_data = alu_result_q;   // ALU and the reserved encoding
    endcase
    if (!valid_q) reg_data = '0;
  end

  assign wb.W_RegWrite    = valid_q & reg_write_q & (a3_q != 5'd0);
  assign wb.W_A3          = a3_q;
  assign wb.W_RegData     = reg_data;
  assign wb.W_PC          = pc_q;
  assign wb.W_Valid       = valid_q;
  assign wb.W_RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_w_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_w_writeback_stage
// Self-checking bench for w_writeback_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the W stage.
// -----------------------------------------------------------------------------
module tb_w_writeback_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  w_writeback_stage_if bus ();

  w_writeback_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Behavioural model of what W holds.
  logic        m_valid, m_rw;
  logic [4:0]  m_a3;
  logic [1:0]  m_sel;
  logic [2:0]  m_lt;
  logic [31:0] m_alu, m_mem, m_pc, m_cnt;

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] lim;
    lim = 32'd1 << (bits - 1);
    return (v >= lim) ? v - (lim << 1) : v;   // two's-complement wrap
  endfunction

  function automatic logic [31:0] model_data();
    logic [31:0] b, h;
    int off;
    if (!m_valid) return 32'd0;
    if (m_sel == 2'd2) return m_pc + 32'd8;
    if (m_sel != 2'd1) return m_alu;
    off = int'(m_alu % 4);
    b = (m_mem >> (8 * off)) % 256;
    h = (m_mem >> (16 * (off / 2))) % 65536;
    case (m_lt)
      3'd1:    return sext(b, 8);
      3'd2:    return b;
      3'd3:    return sext(h, 16);
      3'd4:    return h;
      default: return m_mem;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      {m_valid, m_rw, m_a3, m_sel, m_lt} = '0;
      m_alu = 0; m_mem = 0; m_pc = RESET_PC; m_cnt = 0;
    end else begin
      if (m_valid) m_cnt = m_cnt + 1;
      m_valid = bus.M_Valid;     m_rw  = bus.M_RegWrite;
      m_a3    = bus.M_A3;        m_sel = bus.M_WDSel;
      m_lt    = bus.M_LoadType;  m_alu = bus.M_ALUResult;
      m_mem   = bus.M_MemRData;  m_pc  = bus.M_PC;
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] a3,
                       input logic [1:0] sel, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc);
    bus.M_Valid = v;     bus.M_RegWrite = rw;  bus.M_A3 = a3;
    bus.M_WDSel = sel;   bus.M_LoadType = lt;  bus.M_ALUResult = alu;
    bus.M_MemRData = mem; bus.M_PC = pc;
  endtask

  // One clock: update model at the edge, compare all outputs 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".we"},    32'(bus.W_RegWrite), 32'(m_valid & m_rw & (m_a3 != 0)));
    check({tag, ".a3"},    32'(bus.W_A3),       32'(m_a3));
    check({tag, ".data"},  bus.W_RegData,       model_data());
    check({tag, ".pc"},    bus.W_PC,            m_pc);
    check({tag, ".valid"}, 32'(bus.W_Valid),    32'(m_valid));
    check({tag, ".cnt"},   bus.W_RetireCount,   m_cnt);
  endtask

  initial begin
    logic [31:0] cnt_before;
    m_valid = 0; m_rw = 0; m_a3 = 0; m_sel = 0; m_lt = 0;
    m_alu = 0; m_mem = 0; m_pc = 0; m_cnt = 0;

    // Reset then idle.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h3000);
    step("rst0");
    step("rst1");
    reset = 1'b0;
    step("idle");
    check("idle.pc_const",  bus.W_PC, 32'h0000_3000);
    check("idle.cnt_const", bus.W_RetireCount, 32'd0);

    // ALU write.
    drive(1, 1, 5'd8, 2'b00, 3'd0, 32'h1234_5678, 32'h0, 32'h3004);
    step("alu");
    check("alu.data_const", bus.W_RegData, 32'h1234_5678);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h3008);
    step("alu_cnt");
    check("alu.cnt_const", bus.W_RetireCount, 32'd1);

    // Byte loads.
    drive(1, 1, 5'd9, 2'b01, 3'd1, 32'h1001, 32'h80FF_7F01, 32'h300C);
    step("lb1");  check("lb1.const", bus.W_RegData, 32'h0000_007F);
    drive(1, 1, 5'd9, 2'b01, 3'd1, 32'h1002, 32'h80FF_7F01, 32'h3010);
    step("lb2");  check("lb2.const", bus.W_RegData, 32'hFFFF_FFFF);
    drive(1, 1, 5'd9, 2'b01, 3'd2, 32'h1003, 32'h80FF_7F01, 32'h3014);
    step("lbu3"); check("lbu3.const", bus.W_RegData, 32'h0000_0080);
    drive(1, 1, 5'd9, 2'b01, 3'd1, 32'h1003, 32'h80FF_7F01, 32'h3018);
    step("lb3");  check("lb3.const", bus.W_RegData, 32'hFFFF_FF80);

    // Halfword loads.
    drive(1, 1, 5'd10, 2'b01, 3'd3, 32'h2002, 32'h8001_7FFE, 32'h301C);
    step("lh2");  check("lh2.const", bus.W_RegData, 32'hFFFF_8001);
    drive(1, 1, 5'd10, 2'b01, 3'd4, 32'h2003, 32'h8001_7FFE, 32'h3020);
    step("lhu3"); check("lhu3.const", bus.W_RegData, 32'h0000_8001);
    drive(1, 1, 5'd10, 2'b01, 3'd3, 32'h2000, 32'h8001_7FFE, 32'h3024);
    step("lh0");  check("lh0.const", bus.W_RegData, 32'h0000_7FFE);

    // jal link and $0 gating.
    drive(1, 1, 5'd31, 2'b10, 3'd0, 32'h0, 32'h0, 32'h3010);
    step("jal");  check("jal.const", bus.W_RegData, 32'h0000_3018);
    check("jal.we_const", 32'(bus.W_RegWrite), 32'd1);
    drive(1, 1, 5'd0, 2'b10, 3'd0, 32'h0, 32'h0, 32'h3010);
    step("jal0"); check("jal0.we_const", 32'(bus.W_RegWrite), 32'd0);
    drive(0, 1, 5'd31, 2'b10, 3'd0, 32'h0, 32'h0, 32'h3010);
    step("jalb");
    cnt_before = bus.W_RetireCount;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h3014);
    step("jalb_cnt");
    check("bubble.cnt_hold", bus.W_RetireCount, cnt_before);

    // Reset mid-stream: five valid writes, reset on the sixth edge.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'(i + 1), 2'b00, 3'd0, 32'(i * 7), 32'h0, 32'h4000 + 32'(4 * i));
      step("stream");
    end
    reset = 1'b1;
    drive(1, 1, 5'd3, 2'b01, 3'd1, 32'h1, 32'hFFFF_FFFF, 32'h4014);
    step("midrst");
    check("midrst.cnt_const", bus.W_RetireCount, 32'd0);
    check("midrst.pc_const",  bus.W_PC, 32'h0000_3000);
    reset = 1'b0;

    // Counter wrap: put a valid instruction in W, preset counter to all ones.
    drive(1, 1, 5'd4, 2'b00, 3'd0, 32'h55, 32'h0, 32'h5000);
    step("wrap_fill");
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h5004);
    step("wrap");
    check("wrap.cnt_const", bus.W_RetireCount, 32'd0);

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            2'($urandom), 3'($urandom_range(0, 7)),
            $urandom, $urandom, 32'h6000 + 32'(4 * i));
      step("rand");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
